// File: rtl/cmp_iter_pkg.sv
// rtl/cmp_iter_pkg.sv - shared op encodings, state enumeration and result helpers for cmp_iter
//
// Purpose: common definitions imported by cmp_iter and its testbench-visible behaviour.
// Contents: cmp_op encodings 0-13, invalid-op bound, FSM state type, op classification
//           helpers and the eq/lt -> result mapping.

package cmp_iter_pkg;

  localparam logic [3:0] OP_EQ  = 4'd0;
  localparam logic [3:0] OP_GT  = 4'd1;
  localparam logic [3:0] OP_LT  = 4'd2;
  localparam logic [3:0] OP_NE  = 4'd3;
  localparam logic [3:0] OP_GE  = 4'd4;
  localparam logic [3:0] OP_LE  = 4'd5;
  localparam logic [3:0] OP_EQZ = 4'd6;
  localparam logic [3:0] OP_GTZ = 4'd7;
  localparam logic [3:0] OP_LTZ = 4'd8;
  localparam logic [3:0] OP_NEZ = 4'd9;
  localparam logic [3:0] OP_GEZ = 4'd10;
  localparam logic [3:0] OP_LEZ = 4'd11;
  localparam logic [3:0] OP_LTU = 4'd12;
  localparam logic [3:0] OP_GEU = 4'd13;

  // Codes at or above this bound are rejected with out_err.
  localparam logic [3:0] OP_INVALID_MIN = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Compare-against-zero ops substitute zero for the second operand.
  function automatic logic is_zero_op(input logic [3:0] op);
    return (op >= OP_EQZ) && (op <= OP_LEZ);
  endfunction

  function automatic logic is_unsigned_op(input logic [3:0] op);
    return (op == OP_LTU) || (op == OP_GEU);
  endfunction

  function automatic logic is_invalid_op(input logic [3:0] op);
    return op >= OP_INVALID_MIN;
  endfunction

  // Map the recorded equal/less-than flags onto the requested relation.
  function automatic logic op_result(input logic [3:0] op, input logic eq, input logic lt);
    logic r;
    r = 1'b0;
    case (op)
      OP_EQ, OP_EQZ:         r = eq;
      OP_NE, OP_NEZ:         r = !eq;
      OP_LT, OP_LTZ, OP_LTU: r = lt;
      OP_GE, OP_GEZ, OP_GEU: r = !lt;
      OP_GT, OP_GTZ:         r = !lt && !eq;
      OP_LE, OP_LEZ:         r = lt || eq;
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// rtl/cmp_slice.sv - combinational unsigned compare of one operand slice
//
// Purpose: reports equality and unsigned less-than of two SLICE-wide values.
// Ports:   a, b  - slice values
//          eq    - a == b
//          lt    - a <  b (unsigned)

module cmp_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             eq,
  output logic             lt
);

  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/cmp_iter.sv
// rtl/cmp_iter.sv - iterative slice-serial signed/unsigned comparator with early termination
//
// Purpose: accepts one comparison request at a time and scans the operands SLICE bits per
//          cycle from the MSB end, stopping at the first differing slice.
// Ports:   clk, reset (async, active-low)
//          in_valid/in_ready  - request handshake; num1, num2, cmp_op request fields
//          out_valid/out_ready - result handshake; cmp_out result, out_err invalid-op flag

module cmp_iter
  import cmp_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [3:0]       cmp_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             cmp_out,
  output logic             out_err
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NSLICE - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}} >> 0;

  state_t           state, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [IDX_W-1:0] idx_q;
  logic             eq_q, lt_q;

  logic [WIDTH-1:0] a_cmp, b_cmp, a_sh, b_sh;
  logic [SLICE-1:0] slice_a, slice_b;
  logic             s_eq, s_lt;
  logic             op_bad;
  logic             scan_last;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign a_cmp = is_unsigned_op(op_q) ? a_q : (a_q ^ MSB_MASK);
  assign b_cmp = is_unsigned_op(op_q) ? b_q : (b_q ^ MSB_MASK);

  assign a_sh    = a_cmp >> (idx_q * SLICE);
  assign b_sh    = b_cmp >> (idx_q * SLICE);
  assign slice_a = a_sh[SLICE-1:0];
  assign slice_b = b_sh[SLICE-1:0];

  cmp_slice #(.SLICE(SLICE)) u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .eq (s_eq),
    .lt (s_lt)
  );

  assign op_bad = is_invalid_op(op_q);

  // An invalid op spends exactly one scan cycle; otherwise stop on a difference or the last slice.
  assign scan_last = op_bad || !s_eq || (idx_q == '0);

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cmp_out   = 1'b0;
    out_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (scan_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        out_err   = op_bad;
        cmp_out   = !op_bad && op_result(op_q, eq_q, lt_q);
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      idx_q <= '0;
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q   <= num1;
            b_q   <= is_zero_op(cmp_op) ? '0 : num2;
            op_q  <= cmp_op;
            idx_q <= IDX_TOP;
          end
        end
        ST_SCAN: begin
          if (scan_last) begin
            eq_q <= s_eq;
            lt_q <= s_lt;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_iter.sv
// tb/tb_cmp_iter.sv - scoreboard testbench for cmp_iter across SLICE = 8, 1, 4, 32

module tb_cmp_iter;

  localparam int NI = 4;

  typedef struct {
    logic cmp;
    logic err;
    int   lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid [NI];
  logic        in_ready [NI];
  logic [31:0] num1 [NI];
  logic [31:0] num2 [NI];
  logic [3:0]  cmp_op [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic        cmp_out [NI];
  logic        out_err [NI];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int SL = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
    cmp_iter #(.WIDTH(32), .SLICE(SL)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .num1      (num1[g]),
      .num2      (num2[g]),
      .cmp_op    (cmp_op[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .cmp_out   (cmp_out[g]),
      .out_err   (out_err[g])
    );
  end

  function automatic int slice_of(input int d);
    return (d == 0) ? 8 : (d == 1) ? 1 : (d == 2) ? 4 : 32;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Reference: relation from signed/unsigned integer compare; latency from first differing slice.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b_in,
                                 input logic [3:0] op, input int sl);
    exp_t        e;
    logic [31:0] b, xa, xb;
    logic [63:0] mask, sa, sb_v;
    bit          sgn;
    int          ns;
    b   = (op >= 4'd6 && op <= 4'd11) ? 32'd0 : b_in;
    sgn = !(op == 4'd12 || op == 4'd13);
    e.err = (op >= 4'd14);
    case (op)
      4'd0, 4'd6:  e.cmp = (a == b);
      4'd3, 4'd9:  e.cmp = (a != b);
      4'd2, 4'd8:  e.cmp = ($signed(a) < $signed(b));
      4'd4, 4'd10: e.cmp = ($signed(a) >= $signed(b));
      4'd1, 4'd7:  e.cmp = ($signed(a) > $signed(b));
      4'd5, 4'd11: e.cmp = ($signed(a) <= $signed(b));
      4'd12:       e.cmp = (a < b);
      4'd13:       e.cmp = (a >= b);
      default:     e.cmp = 1'b0;
    endcase
    if (e.err) begin
      e.lat = 1;
    end else begin
      xa   = sgn ? {~a[31], a[30:0]} : a;
      xb   = sgn ? {~b[31], b[30:0]} : b;
      mask = (64'd1 << sl) - 64'd1;
      ns   = 32 / sl;
      e.lat = ns;
      for (int i = ns - 1; i >= 0; i--) begin
        sa   = ({32'd0, xa} >> (i * sl)) & mask;
        sb_v = ({32'd0, xb} >> (i * sl)) & mask;
        if (sa != sb_v) begin
          e.lat = ns - i;
          break;
        end
      end
    end
    return e;
  endfunction

  task automatic run(input int d, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] op, input int hold);
    exp_t e, p;
    bit   seen;
    int   k;
    logic c0, e0;
    e = model(a, b, op, slice_of(d));
    check("in_ready_before_req", 32'(in_ready[d]), 32'd1);
    num1[d] = a; num2[d] = b; cmp_op[d] = op; in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    sb.push_back(e);
    check("in_ready_after_accept", 32'(in_ready[d]), 32'd0);
    seen = 0;
    k = 0;
    while (!seen && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (out_valid[d]) seen = 1;
    end
    p = sb.pop_front();
    if (!seen) begin
      check("timeout_out_valid", 32'd0, 32'd1);
      return;
    end
    check($sformatf("lat_i%0d_op%0d", d, op), 32'(k), 32'(p.lat));
    check($sformatf("cmp_i%0d_op%0d_%h_%h", d, op, a, b), 32'(cmp_out[d]), 32'(p.cmp));
    check($sformatf("err_i%0d_op%0d", d, op), 32'(out_err[d]), 32'(p.err));
    check("no_ready_with_valid", 32'(in_ready[d]), 32'd0);
    c0 = cmp_out[d]; e0 = out_err[d];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid[d]), 32'd1);
      check("hold_cmp", 32'(cmp_out[d]), 32'(c0));
      check("hold_err", 32'(out_err[d]), 32'(e0));
      check("hold_in_ready", 32'(in_ready[d]), 32'd0);
    end
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    check("consumed_valid", 32'(out_valid[d]), 32'd0);
    check("consumed_cmp", 32'(cmp_out[d]), 32'd0);
    check("consumed_in_ready", 32'(in_ready[d]), 32'd1);
  endtask

  initial begin
    logic [31:0] a, b;
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      num1[i] = '0; num2[i] = '0; cmp_op[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check("rst_in_ready", 32'(in_ready[i]), 32'd1);
      check("rst_out_valid", 32'(out_valid[i]), 32'd0);
      check("rst_cmp_out", 32'(cmp_out[i]), 32'd0);
      check("rst_out_err", 32'(out_err[i]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases on the SLICE=8 instance
    run(0, 32'h12345678, 32'h12345678, 4'd0, 0);
    check("eq_directed_lat4", 32'(model(32'h12345678, 32'h12345678, 4'd0, 8).lat), 32'd4);
    run(0, 32'h12345678, 32'h12345678, 4'd3, 0);
    run(0, 32'h80000000, 32'h00000001, 4'd2, 0);
    run(0, 32'h80000000, 32'h00000001, 4'd12, 0);
    run(0, 32'hFFFFFFFF, 32'hDEADBEEF, 4'd11, 0);
    run(0, 32'h00000000, 32'hDEADBEEF, 4'd7, 0);
    run(0, 32'h00000000, 32'hDEADBEEF, 4'd10, 0);
    run(0, 32'h12345678, 32'h9ABCDEF0, 4'd15, 5);
    run(0, 32'h12345678, 32'h9ABCDEF0, 4'd14, 0);

    // Reset pulsed mid-scan aborts the pending result
    num1[0] = 32'd0; num2[0] = 32'd0; cmp_op[0] = 4'd0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid[0]), 32'd0);
    check("abort_in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("abort_no_result", 32'(out_valid[0]), 32'd0);
    end
    run(0, 32'h00000000, 32'h00000000, 4'd0, 0);

    // Random sweep of every op on every slice width
    for (int d = 0; d < NI; d++) begin
      for (int op = 0; op < 16; op++) begin
        for (int v = 0; v < 4; v++) begin
          a = $urandom;
          case (v)
            0: b = $urandom;
            1: b = a;
            2: b = a ^ (32'd1 << $urandom_range(31, 0));
            default: b = {a[31:16], 16'($urandom)};
          endcase
          run(d, a, b, 4'(op), (v == 0) ? 1 : 0);
        end
      end
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
